dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the load/store reservation station's dmem request interface (dmem_addr/dmem_read/dmem_write/dmem_wdata/dmem_byte_enable).
- Accepts one level-held request at a time and runs it as a multi-cycle transaction on the data-cache port.
- For loads, returns the full 16-bit word as mem_val_out with a one-cycle ld_mem_val strobe; ldb byte selection stays in the station. For stores, returns a one-cycle dmem_ack.
- Sits between the ld/str reservation station and the L1 data cache; handles flush by completing memory-side work and suppressing the response.

Parameters:
- TIMEOUT, 64, cycles an outstanding cache access may wait for mem_resp before err_timeout sets.
- CNT_WIDTH, 7, width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush (branch mispredict).
- dmem_read  in  1  load request, level-held by requester until ld_mem_val.
- dmem_write  in  1  store request, level-held until dmem_ack.
- dmem_addr  in  16  byte address (lc3b_word).
- dmem_wdata  in  16  store data.
- dmem_byte_enable  in  2  store byte mask (lc3b_mem_wmask).
- mem_val_out  out  16  load data returned to the station.
- ld_mem_val  out  1  one-cycle load-complete strobe.
- dmem_ack  out  1  one-cycle store-complete strobe.
- busy  out  1  transaction outstanding.
- mem_address  out  16  cache address, bit0 forced to 0.
- mem_read  out  1  cache read.
- mem_write  out  1  cache write.
- mem_wdata  out  16  cache write data.
- mem_byte_enable  out  2  cache byte mask.
- mem_rdata  in  16  cache read data.
- mem_resp  in  1  cache completion, single cycle.
- err_timeout  out  1  sticky, set on wait-counter expiry.
- err_protocol  out  1  sticky, set when dmem_read and dmem_write are both high in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: mem_val_out=0, strobes 0, mem_* 0, busy=0.
  - Error flags cleared; squash flag cleared; wait counter=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If flush: accept nothing.
  - Else if dmem_write: latch addr/wdata/byte_enable, go to WRITE. A write wins when both requests are high; in that case also set err_protocol.
  - Else if dmem_read: latch addr, go to READ.
- Latched request: drives mem_* registers from the next cycle onward, so the cache sees the request 1 cycle after acceptance. The requester's later input changes are ignored.
- READ: mem_read=1, mem_byte_enable=2'b11.
  - On mem_resp: capture mem_rdata into mem_val_out, go to DONE.
  - If not squashed, ld_mem_val=1 for exactly that DONE-entry cycle.
- WRITE: mem_write=1.
  - On mem_resp: go to DONE.
  - If not squashed, dmem_ack=1 for one cycle.
- Minimum latency: request high at cycle 0, cache request at cycle 1, mem_resp at cycle 1 gives the strobe at cycle 2.
- DONE: one dead cycle so the requester can drop its level request. No acceptance in DONE; always return to IDLE.
- mem_val_out holds its last value until the next load completes.
- flush while in READ or WRITE:
  - The cache transaction is not aborted; it runs to mem_resp.
  - The squash flag is set, the strobe for that transaction is suppressed, and squash clears on the DONE exit.
- flush in DONE: has no effect, because the strobe was already issued.
- Wait counter: clears on entry to READ/WRITE and increments each cycle without mem_resp.
  - At count == TIMEOUT-1, set err_timeout. The state stays put; the cache is the only exit.
  - The counter saturates, never wraps.
- busy = (state != IDLE).
- mem_address = {addr[15:1],1'b0} for both reads and writes.

Decomposition:
- Shared package: responder state enum (dmem_resp_state_t), plus existing lc3b_word and lc3b_mem_wmask.
- Sub-module: a saturating wait counter, dmem_wait_counter (clr, inc, expired). Everything else stays in a single module.

Test Plan:
- Load: dmem_read, addr=0x1235; cache returns 0xBEEF after 3 cycles -> mem_address=0x1234, mem_read held 3 cycles, ld_mem_val pulse, mem_val_out=0xBEEF, then DONE, then IDLE.
- Store: dmem_write, addr=0x2001, wdata=0x00AA, be=2'b10; mem_resp after 1 cycle -> mem_write with be=2'b10, mem_address=0x2000, single dmem_ack, no ld_mem_val.
- Flush mid-load: flush while in READ, mem_resp 2 cycles later -> no ld_mem_val, mem_read stays asserted until resp, busy drops after DONE.
- Back-to-back: requester holds dmem_read through DONE -> no second acceptance in DONE; a new transaction starts from IDLE the following cycle.
- Both requests high in IDLE -> WRITE taken, err_protocol=1 and sticky until reset.
- mem_resp withheld for TIMEOUT cycles -> err_timeout=1 at cycle TIMEOUT, state still READ; assert rst_n=0 mid-READ -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types for the dmem responder
package dmem_responder_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dmem_resp_state_t;

  localparam lc3b_mem_wmask BE_FULL = 2'b11;

  function automatic lc3b_word word_align(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - requester-side and cache-side signals of the dmem responder
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic          dmem_read;
  logic          dmem_write;
  lc3b_word      dmem_addr;
  lc3b_word      dmem_wdata;
  lc3b_mem_wmask dmem_byte_enable;
  lc3b_word      mem_val_out;
  logic          ld_mem_val;
  logic          dmem_ack;

  lc3b_word      mem_address;
  logic          mem_read;
  logic          mem_write;
  lc3b_word      mem_wdata;
  lc3b_mem_wmask mem_byte_enable;
  lc3b_word      mem_rdata;
  logic          mem_resp;

  modport slave (
    input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_enable,
    input  mem_rdata, mem_resp,
    output mem_val_out, ld_mem_val, dmem_ack,
    output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable
  );

  modport master (
    output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_enable,
    output mem_rdata, mem_resp,
    input  mem_val_out, ld_mem_val, dmem_ack,
    input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable
  );

endinterface

// File: rtl/dmem_wait_counter.sv
// rtl/dmem_wait_counter.sv - saturating wait counter for an outstanding cache access
module dmem_wait_counter #(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_WIDTH = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pulses on the step that lands the count on TIMEOUT-1, so the sticky flag shows that same cycle.
  assign expired = inc && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - runs one level-held dmem load/store as a cache transaction
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_WIDTH = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  dmem_responder_if.slave bus,
  output logic            busy,
  output logic            err_timeout,
  output logic            err_protocol
);

  dmem_resp_state_t state_q, state_d;

  lc3b_word      addr_q, addr_d;
  lc3b_word      wdata_q, wdata_d;
  lc3b_mem_wmask be_q, be_d;
  lc3b_word      val_q, val_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          ld_q, ld_d;
  logic          ack_q, ack_d;
  logic          squash_q, squash_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_protocol_q, err_protocol_d;

  logic accept;
  logic waiting;
  logic suppress;
  logic wait_inc;
  logic expired;

  assign waiting  = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign accept   = (state_q == ST_IDLE) && !flush && (bus.dmem_read || bus.dmem_write);
  assign suppress = squash_q || flush;
  assign wait_inc = waiting && !bus.mem_resp;

  dmem_wait_counter #(
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .inc     (wait_inc),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          if (bus.dmem_write) begin
            state_d = ST_WRITE;
          end else if (bus.dmem_read) begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ, ST_WRITE: begin
        if (bus.mem_resp) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    val_d          = val_q;
    mem_read_d     = (state_d == ST_READ);
    mem_write_d    = (state_d == ST_WRITE);
    ld_d           = 1'b0;
    ack_d          = 1'b0;
    squash_d       = squash_q;
    err_timeout_d  = err_timeout_q || expired;
    err_protocol_d = err_protocol_q || (accept && bus.dmem_read && bus.dmem_write);

    if (accept) begin
      addr_d = word_align(bus.dmem_addr);
      if (bus.dmem_write) begin
        wdata_d = bus.dmem_wdata;
        be_d    = bus.dmem_byte_enable;
      end else begin
        be_d    = BE_FULL;
      end
    end

    // A flush landing on the response cycle itself still suppresses the strobe.
    if (waiting && bus.mem_resp) begin
      if (state_q == ST_READ) begin
        val_d = bus.mem_rdata;
        ld_d  = !suppress;
      end else begin
        ack_d = !suppress;
      end
    end

    if (waiting && flush) begin
      squash_d = 1'b1;
    end
    if (state_q == ST_DONE) begin
      squash_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      val_q          <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      ld_q           <= 1'b0;
      ack_q          <= 1'b0;
      squash_q       <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_protocol_q <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      val_q          <= val_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      ld_q           <= ld_d;
      ack_q          <= ack_d;
      squash_q       <= squash_d;
      err_timeout_q  <= err_timeout_d;
      err_protocol_q <= err_protocol_d;
    end
  end

  assign busy                = (state_q != ST_IDLE);
  assign err_timeout         = err_timeout_q;
  assign err_protocol        = err_protocol_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_byte_enable = be_q;
  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_val_out     = val_q;
  assign bus.ld_mem_val      = ld_q;
  assign bus.dmem_ack        = ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and random checks of dmem_responder against a transaction model
module tb_dmem_responder;

  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic busy, err_timeout, err_protocol;

  dmem_responder_if bus ();

  dmem_responder #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_protocol (err_protocol)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_n(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request is either talking to the cache or sitting in its dead cycle.
  bit          m_in_cache, m_dead, m_load, m_squash;
  int          m_waits;
  logic [15:0] e_val, e_addr, e_wdata;
  logic [1:0]  e_be;
  bit          e_ld, e_ack, e_errt, e_errp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_cache = 0; m_dead = 0; m_load = 0; m_squash = 0; m_waits = 0;
      e_val = '0; e_addr = '0; e_wdata = '0; e_be = '0;
      e_ld = 0; e_ack = 0; e_errt = 0; e_errp = 0;
    end else begin
      e_ld  = 0;
      e_ack = 0;
      if (m_dead) begin
        m_dead   = 0;
        m_squash = 0;
      end else if (m_in_cache) begin
        if (flush) m_squash = 1;
        if (bus.mem_resp) begin
          m_in_cache = 0;
          m_dead     = 1;
          if (m_load) begin
            e_val = bus.mem_rdata;
            e_ld  = !m_squash;
          end else begin
            e_ack = !m_squash;
          end
        end else begin
          m_waits++;
          if (m_waits == TIMEOUT - 1) e_errt = 1;
        end
      end else if (!flush && (bus.dmem_read || bus.dmem_write)) begin
        m_load     = !bus.dmem_write;
        m_in_cache = 1;
        m_waits    = 0;
        e_addr     = bus.dmem_addr & 16'hFFFE;
        if (m_load) begin
          e_be = 2'b11;
        end else begin
          e_be    = bus.dmem_byte_enable;
          e_wdata = bus.dmem_wdata;
        end
        if (bus.dmem_read && bus.dmem_write) e_errp = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk_bit("busy", busy, m_in_cache || m_dead);
    chk_bit("mem_read", bus.mem_read, m_in_cache && m_load);
    chk_bit("mem_write", bus.mem_write, m_in_cache && !m_load);
    chk_bit("ld_mem_val", bus.ld_mem_val, e_ld);
    chk_bit("dmem_ack", bus.dmem_ack, e_ack);
    chk_w("mem_val_out", bus.mem_val_out, e_val);
    chk_bit("err_timeout", err_timeout, e_errt);
    chk_bit("err_protocol", err_protocol, e_errp);
    if (m_in_cache) begin
      chk_w("mem_address", bus.mem_address, e_addr);
      chk_w("mem_byte_enable", 16'(bus.mem_byte_enable), 16'(e_be));
      if (!m_load) chk_w("mem_wdata", bus.mem_wdata, e_wdata);
    end
  end

  // Cache stand-in: answers each access after cache_lat cycles unless stalled.
  int          cache_lat   = 1;
  int          cache_cnt   = 0;
  bit          cache_rand  = 0;
  bit          cache_stall = 0;
  bit          rand_word   = 0;
  logic [15:0] rd_word     = 16'h0000;

  always @(negedge clk) begin
    bus.mem_resp = 1'b0;
    if (bus.mem_read || bus.mem_write) begin
      cache_cnt++;
      if (!cache_stall && cache_cnt >= cache_lat) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rand_word ? 16'($urandom) : rd_word;
        cache_cnt     = 0;
        if (cache_rand) cache_lat = $urandom_range(1, 4);
      end
    end else begin
      cache_cnt = 0;
    end
  end

  int          n_ld, n_ack, n_rd, n_wr;
  logic [15:0] seen_addr, seen_wdata;
  logic [1:0]  seen_be;

  always @(negedge clk) begin
    if (bus.ld_mem_val) n_ld++;
    if (bus.dmem_ack)   n_ack++;
    if (bus.mem_read)   n_rd++;
    if (bus.mem_write)  n_wr++;
    if (bus.mem_read || bus.mem_write) begin
      seen_addr  = bus.mem_address;
      seen_wdata = bus.mem_wdata;
      seen_be    = bus.mem_byte_enable;
    end
  end

  task automatic clr_stats();
    n_ld = 0; n_ack = 0; n_rd = 0; n_wr = 0;
  endtask

  task automatic wait_strobe(input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ld_mem_val || bus.dmem_ack;
    end
    chk_bit({name, "_strobe_seen"}, seen, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit holding;
    bus.dmem_read = 1'b0; bus.dmem_write = 1'b0;
    bus.dmem_addr = '0; bus.dmem_wdata = '0; bus.dmem_byte_enable = '0;
    #1 rst_n = 1'b0;
    #3;
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_mem_read", bus.mem_read, 1'b0);
    chk_w("rst_mem_address", bus.mem_address, 16'h0000);
    chk_w("rst_mem_val_out", bus.mem_val_out, 16'h0000);
    chk_bit("rst_err_protocol", err_protocol, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Load, 3-cycle cache latency
    clr_stats(); cache_lat = 3; rd_word = 16'hBEEF;
    @(negedge clk); bus.dmem_addr = 16'h1235; bus.dmem_read = 1'b1;
    wait_strobe("load");
    chk_w("load_val", bus.mem_val_out, 16'hBEEF);
    chk_bit("load_busy_done", busy, 1'b1);
    bus.dmem_read = 1'b0;
    @(negedge clk); chk_bit("load_idle_after", busy, 1'b0);
    @(negedge clk);
    chk_n("load_rd_cycles", n_rd, 3);
    chk_n("load_ld_pulses", n_ld, 1);
    chk_w("load_addr", seen_addr, 16'h1234);
    chk_w("model_val_pin", e_val, 16'hBEEF);

    // Store, 1-cycle latency
    clr_stats(); cache_lat = 1;
    @(negedge clk); bus.dmem_addr = 16'h2001; bus.dmem_wdata = 16'h00AA;
    bus.dmem_byte_enable = 2'b10; bus.dmem_write = 1'b1;
    wait_strobe("store");
    bus.dmem_write = 1'b0;
    repeat (2) @(negedge clk);
    chk_n("store_wr_cycles", n_wr, 1);
    chk_n("store_acks", n_ack, 1);
    chk_n("store_no_ld", n_ld, 0);
    chk_w("store_addr", seen_addr, 16'h2000);
    chk_w("store_be", 16'(seen_be), 16'h0002);
    chk_w("store_wdata", seen_wdata, 16'h00AA);

    // Flush mid-load: cache finishes, strobe suppressed
    clr_stats(); cache_lat = 4; rd_word = 16'h4321;
    @(negedge clk); bus.dmem_addr = 16'h0040; bus.dmem_read = 1'b1;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; bus.dmem_read = 1'b0;
    repeat (5) @(negedge clk);
    chk_n("flush_no_ld", n_ld, 0);
    chk_n("flush_rd_cycles", n_rd, 4);
    chk_bit("flush_idle", busy, 1'b0);

    // Back-to-back: held request is not re-accepted in the dead cycle
    clr_stats(); cache_lat = 1; rd_word = 16'h1111;
    @(negedge clk); bus.dmem_addr = 16'h0100; bus.dmem_read = 1'b1;
    wait_strobe("b2b_first");
    @(negedge clk);
    chk_bit("b2b_idle_gap", busy, 1'b0);
    chk_bit("b2b_no_read_gap", bus.mem_read, 1'b0);
    @(negedge clk);
    chk_bit("b2b_second_read", bus.mem_read, 1'b1);
    wait_strobe("b2b_second");
    bus.dmem_read = 1'b0;
    repeat (2) @(negedge clk);
    chk_n("b2b_ld_pulses", n_ld, 2);

    // Both requests high: write wins and the protocol error latches
    chk_bit("proto_clear_before", err_protocol, 1'b0);
    @(negedge clk); bus.dmem_addr = 16'h3003; bus.dmem_wdata = 16'h5A5A;
    bus.dmem_byte_enable = 2'b01; bus.dmem_read = 1'b1; bus.dmem_write = 1'b1;
    wait_strobe("proto");
    chk_bit("proto_ack", bus.dmem_ack, 1'b1);
    chk_bit("proto_no_ld", bus.ld_mem_val, 1'b0);
    bus.dmem_read = 1'b0; bus.dmem_write = 1'b0;
    @(negedge clk);
    chk_bit("proto_set", err_protocol, 1'b1);
    chk_w("proto_wdata", seen_wdata, 16'h5A5A);
    chk_bit("model_errp_pin", e_errp, 1'b1);

    // Random traffic with random flushes and latencies
    cache_rand = 1; rand_word = 1; holding = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      flush = ($urandom_range(0, 11) == 0);
      if (holding && (flush || ((bus.ld_mem_val || bus.dmem_ack) && $urandom_range(0, 3) != 0))) begin
        bus.dmem_read = 1'b0; bus.dmem_write = 1'b0; holding = 0;
      end else if (!holding && $urandom_range(0, 2) == 0) begin
        bus.dmem_addr        = 16'($urandom);
        bus.dmem_wdata       = 16'($urandom);
        bus.dmem_byte_enable = 2'($urandom);
        if ($urandom_range(0, 1) == 1) bus.dmem_write = 1'b1;
        else                           bus.dmem_read  = 1'b1;
        holding = 1;
      end
    end
    @(negedge clk); flush = 1'b0; bus.dmem_read = 1'b0; bus.dmem_write = 1'b0;
    cache_rand = 0; rand_word = 0;
    repeat (10) @(negedge clk);
    chk_bit("proto_sticky", err_protocol, 1'b1);
    chk_bit("no_timeout_yet", err_timeout, 1'b0);

    // Timeout: cache never answers
    cache_stall = 1;
    @(negedge clk); bus.dmem_addr = 16'h0ACE; bus.dmem_read = 1'b1;
    repeat (TIMEOUT - 1) @(negedge clk);
    chk_bit("timeout_not_yet", err_timeout, 1'b0);
    @(negedge clk);
    chk_bit("timeout_set", err_timeout, 1'b1);
    chk_bit("timeout_busy", busy, 1'b1);
    chk_bit("timeout_still_read", bus.mem_read, 1'b1);

    // Asynchronous reset in the middle of the stalled read
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk_bit("arst_busy", busy, 1'b0);
    chk_bit("arst_mem_read", bus.mem_read, 1'b0);
    chk_w("arst_mem_address", bus.mem_address, 16'h0000);
    chk_bit("arst_err_timeout", err_timeout, 1'b0);
    chk_bit("arst_err_protocol", err_protocol, 1'b0);
    bus.dmem_read = 1'b0; cache_stall = 0;
    @(negedge clk); rst_n = 1'b1;

    // Normal operation after reset
    cache_lat = 2; rd_word = 16'h1357;
    @(negedge clk); bus.dmem_addr = 16'h7777; bus.dmem_read = 1'b1;
    wait_strobe("post_rst");
    chk_w("post_rst_val", bus.mem_val_out, 16'h1357);
    bus.dmem_read = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
